// File: rtl/skinny_sbox_layer.sv
// skinny_sbox_layer: iterative SKINNY-64 S-box layer, LANES nibbles per cycle,
// forward or inverse per transaction, valid/ready on both sides.
module skinny_sbox_layer #(
   parameter int NUM_SBOX = 16,
   parameter int LANES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_inv,
   input  logic [4*NUM_SBOX-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*NUM_SBOX-1:0] out_data,
   output logic                  busy
);
   localparam int N = NUM_SBOX / LANES;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam logic [63:0] FWD = 64'hF7E4D583B2A1096C;
   localparam logic [63:0] INV = 64'hFDB07529E1AC8643;
   if (NUM_SBOX < 1 || NUM_SBOX > 64 || LANES < 1 || NUM_SBOX % LANES != 0) begin : g_bad_params
      $error("skinny_sbox_layer: LANES must divide NUM_SBOX (1..64)");
   end
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nxt;
   logic [4*NUM_SBOX-1:0] st, st_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic mode, mode_nxt;
   logic last;
   logic [4*LANES-1:0] chunk, img;
   assign chunk = st[4*LANES*int'(cnt) +: 4*LANES];
   assign last = cnt == CW'(N - 1);
   // the only S-box tables in the design: one per lane
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [3:0] x;
      assign x = chunk[4*j +: 4];
      assign img[4*j +: 4] = mode ? INV[{x, 2'b00} +: 4] : FWD[{x, 2'b00} +: 4];
   end
   always_comb begin
      state_nxt = state;
      st_nxt = st;
      cnt_nxt = cnt;
      mode_nxt = mode;
      if (state == IDLE && in_valid) begin
         state_nxt = BUSY;
         st_nxt = in_data;
         cnt_nxt = '0;
         mode_nxt = in_inv;
      end else if (state == BUSY) begin
         st_nxt[4*LANES*int'(cnt) +: 4*LANES] = img;
         cnt_nxt = last ? '0 : cnt + CW'(1);
         state_nxt = last ? DONE : BUSY;
      end else if (state == DONE && out_ready) begin
         state_nxt = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         st <= '0;
         cnt <= '0;
         mode <= 1'b0;
      end else begin
         state <= state_nxt;
         st <= st_nxt;
         cnt <= cnt_nxt;
         mode <= mode_nxt;
      end
   end
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   assign busy = state != IDLE;
   assign out_data = st;
endmodule

// File: tb/tb_skinny_sbox_layer.sv
// tb_skinny_sbox_layer: KAT vector table and corner-case sequences on the default
// instance, plus a parallel random sweep across LANES/NUM_SBOX with scoreboards.
module tb_skinny_sbox_layer;
   logic clk = 0;
   always #5 clk = ~clk;
   int n_cmp = 0, n_bad = 0;
   logic rst = 1, in_valid = 0, in_inv = 0, out_ready = 0;
   logic in_ready, out_valid, busy;
   logic [63:0] in_data = '0, out_data;
   logic [63:0] q[$];
   localparam logic [3:0] FT [16] = '{4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
                                       4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF};
   localparam logic [3:0] IT [16] = '{4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
                                       4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF};
   typedef struct {
      logic [63:0] d;
      logic        inv;
      logic [63:0] e;
      string       nm;
   } vec_t;
   vec_t vt [4];
   skinny_sbox_layer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy)
   );
   function automatic logic [63:0] model(input logic [63:0] x, input int n, input logic inv);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r[4*i +: 4] = inv ? IT[x[4*i +: 4]] : FT[x[4*i +: 4]];
      return r;
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask
   task automatic accept(input logic [63:0] d, input logic inv, input logic [63:0] exp, input bit push);
      int w;
      w = 0;
      in_data = d;
      in_inv = inv;
      in_valid = 1;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("accept_ready", in_ready, 1);
      if (push) q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 0;
      in_data = {$urandom, $urandom};
      in_inv = 1'($urandom_range(0, 1));
   endtask
   task automatic recv(input string nm, input int hold);
      int lat;
      logic [63:0] exp, held;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         in_valid = 1'($urandom_range(0, 1));
         in_data = {$urandom, $urandom};
         in_inv = 1'($urandom_range(0, 1));
      end while (!out_valid && lat < 50);
      chk({nm, "_lat"}, 64'(lat), 5);
      exp = q.size() > 0 ? q.pop_front() : '1;
      chk({nm, "_data"}, out_data, exp);
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = {$urandom, $urandom};
         in_inv = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("hold_data", out_data, held);
         chk("hold_ready", in_ready, 0);
         chk("hold_valid", out_valid, 1);
      end
      in_valid = 0;
      out_ready = 1;
      @(posedge clk);
      #1 out_ready = 0;
   endtask
   // random sweep instances; each pair of transactions is x -> S(x) -> S^-1(S(x)) = x
   for (genvar g = 0; g < 6; g++) begin : sw
      localparam int NS = g == 5 ? 1 : 16;
      localparam int LN = g == 5 ? 1 : 1 << g;
      localparam logic [63:0] MASK = NS == 16 ? '1 : 64'hF;
      logic s_rst = 1, s_iv = 0, s_ii = 0, s_or = 0, dn = 0;
      logic s_ir, s_ov, s_bz;
      logic [4*NS-1:0] s_id = '0, s_od;
      logic [63:0] sq[$];
      skinny_sbox_layer #(.NUM_SBOX(NS), .LANES(LN)) u (
         .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir), .in_inv(s_ii),
         .in_data(s_id), .out_valid(s_ov), .out_ready(s_or), .out_data(s_od), .busy(s_bz)
      );
      initial begin
         logic [63:0] x, cur, e;
         logic m;
         int lat;
         repeat (2) @(posedge clk);
         #1 s_rst = 0;
         for (int i = 0; i < 500; i++) begin
            x = {$urandom, $urandom} & MASK;
            m = 1'($urandom_range(0, 1));
            cur = x;
            for (int p = 0; p < 2; p++) begin
               s_id = cur[4*NS-1:0];
               s_ii = m;
               s_iv = 1;
               sq.push_back(p == 0 ? model(cur, NS, m) : x);
               @(negedge clk);
               chk("sweep_ready", s_ir, 1);
               @(posedge clk);
               #1 s_iv = 0;
               lat = 0;
               do begin
                  @(negedge clk);
                  lat++;
               end while (!s_ov && lat < 40);
               chk("sweep_lat", 64'(lat), 64'(NS / LN + 1));
               e = sq.pop_front();
               if (p == 0) chk("sweep_data", 64'(s_od), e);
               else chk("sweep_roundtrip", 64'(s_od), e);
               cur = 64'(s_od);
               m = ~m;
               s_or = 1;
               @(posedge clk);
               #1 s_or = 0;
            end
         end
         dn = 1;
      end
   end
   initial begin
      logic seen;
      int w;
      vt[0] = '{64'h0123456789ABCDEF, 1'b0, 64'hC6901A2B385D4E7F, "kat_fwd"};
      vt[1] = '{64'hC6901A2B385D4E7F, 1'b1, 64'h0123456789ABCDEF, "kat_inv"};
      vt[2] = '{64'h0000000000000000, 1'b0, 64'hCCCCCCCCCCCCCCCC, "kat_zero"};
      vt[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFFF, "kat_ff_inv"};
      repeat (2) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      out_ready = 1;
      repeat (10) begin
         @(negedge clk);
         chk("idle_ready", in_ready, 1);
         chk("idle_busy", busy, 0);
      end
      @(posedge clk);
      #1 out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         accept(vt[i].d, vt[i].inv, vt[i].e, 1);
         recv(vt[i].nm, 0);
      end
      // backpressure, ignored inputs, and back-to-back acceptance after release
      accept(64'h0123456789ABCDEF, 0, 64'hC6901A2B385D4E7F, 1);
      recv("bp", 20);
      chk("bp_release_ready", in_ready, 1);
      chk("bp_release_valid", out_valid, 0);
      accept(64'h0, 1, 64'h3333333333333333, 1);
      chk("bp_reaccept_busy", busy, 1);
      recv("bp_next", 0);
      // reset in the second BUSY cycle
      accept(64'hFEDCBA9876543210, 0, 64'h0, 0);
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1 rst = 0;
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_data", out_data, 0);
      seen = out_valid;
      repeat (10) begin
         @(negedge clk);
         seen |= out_valid;
      end
      chk("mid_rst_no_valid", seen, 0);
      @(posedge clk);
      #1;
      accept(64'h0123456789ABCDEF, 0, 64'hC6901A2B385D4E7F, 1);
      recv("post_rst_kat", 0);
      w = 0;
      while (!(sw[0].dn && sw[1].dn && sw[2].dn && sw[3].dn && sw[4].dn && sw[5].dn) && w < 60000) begin
         @(posedge clk);
         w++;
      end
      chk("sweep_done", {sw[5].dn, sw[4].dn, sw[3].dn, sw[2].dn, sw[1].dn, sw[0].dn}, 6'h3F);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
